// File: rtl/csk_block_subtractor_if.sv
// Handshake and operand/result bundle for the block-serial borrow-skip subtractor.
// The producer/consumer uses the master view and the subtractor uses the slave view.
interface csk_block_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned NBLK  = WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NBLK) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, skip_cnt
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, skip_cnt
  );
endinterface

// File: rtl/csk_block_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit block per clock.
// A block whose bit pairs are all equal forwards its incoming borrow through a skip mux.
module csk_block_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csk_block_subtractor_if.slave bus
);
  localparam int unsigned NBLK  = WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NBLK) + 1;
  localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;

  logic [3:0]         blk_a, blk_b, blk_d;
  logic [4:0]         brv;
  logic               blk_p, blk_bo;

  // Current block: ripple borrow chain plus propagate-driven skip mux
  always_comb begin
    blk_a  = a_q[{idx_q, 2'b00} +: 4];
    blk_b  = b_q[{idx_q, 2'b00} +: 4];
    brv    = '0;
    blk_d  = '0;
    brv[0] = br_q;
    for (int j = 0; j < 4; j++) begin
      blk_d[j]   = blk_a[j] ^ blk_b[j] ^ brv[j];
      brv[j+1]   = (~blk_a[j] & blk_b[j]) | (~(blk_a[j] ^ blk_b[j]) & brv[j]);
    end
    blk_p  = &(~(blk_a ^ blk_b));
    blk_bo = blk_p ? br_q : brv[4];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    br_d        = br_q;
    idx_d       = idx_q;
    skip_d      = skip_q;
    part_d      = part_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    skip_cnt_d  = skip_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          idx_d   = '0;
          skip_d  = '0;
          part_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        part_d[{idx_q, 2'b00} +: 4] = blk_d;
        br_d   = blk_bo;
        skip_d = skip_q + CNT_W'(blk_p);
        idx_d  = IDX_W'(idx_q + 1'b1);
        // Last block: publish the result on the same edge as DONE entry
        if (idx_q == IDX_W'(NBLK - 1)) begin
          state_d     = DONE;
          diff_d      = part_d;
          bout_d      = blk_bo;
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
          skip_cnt_d  = skip_d;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      idx_q       <= '0;
      skip_q      <= '0;
      part_q      <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      skip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      br_q        <= br_d;
      idx_q       <= idx_d;
      skip_q      <= skip_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      skip_cnt_q  <= skip_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_csk_block_subtractor.sv
// Randomized self-checking bench for csk_block_subtractor against an arithmetic reference.
module tb_csk_block_subtractor;
  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  csk_block_subtractor_if #(.WIDTH(W)) bus ();

  csk_block_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact WIDTH+1 bit difference, signed range test, equal-nibble count
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin,
                        input int hold, input bit spurious, input bit dual);
    logic [16:0] full;
    int          sres;
    int          exp_skip;
    logic        exp_ovf;
    int          n;
    int          lat;
    full     = {1'b0, ta} - {1'b0, tbv} - 17'(tbin);
    sres     = int'($signed(ta)) - int'($signed(tbv)) - int'(tbin);
    exp_ovf  = (sres > 32767) || (sres < -32768);
    exp_skip = 0;
    for (int k = 0; k < 4; k++)
      if (((ta >> (4 * k)) & 16'hF) == ((tbv >> (4 * k)) & 16'hF)) exp_skip++;

    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.a = ta; bus.b = tbv; bus.bin = tbin; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      if (spurious && lat == 1) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom); bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency",  32'(lat),          32'd4);
    chk("diff",     32'(bus.diff),     32'(full[15:0]));
    chk("bout",     32'(bus.bout),     32'(full[16]));
    chk("ovf",      32'(bus.ovf),      32'(exp_ovf));
    chk("skip_cnt", 32'(bus.skip_cnt), 32'(exp_skip));
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_diff",  32'(bus.diff),      32'(full[15:0]));
      chk("hold_skip",  32'(bus.skip_cnt),  32'(exp_skip));
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    if (dual) begin
      bus.a = 16'hFFFF; bus.b = 16'h0001; bus.bin = 1'b0; bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("retire_valid", 32'(bus.out_valid), 32'd0);
    if (dual) begin
      // Not taken in DONE, so the IDLE state must still be offering in_ready
      chk("dual_not_taken", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end
    chk("retire_diff", 32'(bus.diff), 32'(full[15:0]));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_diff",     32'(bus.diff),      32'd0);
    chk("rst_bout",     32'(bus.bout),      32'd0);
    chk("rst_ovf",      32'(bus.ovf),       32'd0);
    chk("rst_skip",     32'(bus.skip_cnt),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready),  32'd1);

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h5555, 16'h5555, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 5, 1'b1, 1'b1);

    // Reset during BUSY cycle 2 discards the operation
    run_op(16'hABCD, 16'h1111, 1'b0, 0, 1'b0, 1'b0);
    bus.a = 16'h4321; bus.b = 16'h1234; bus.bin = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_diff",  32'(bus.diff),      32'd0);
    chk("mid_rst_skip",  32'(bus.skip_cnt),  32'd0);
    chk("mid_rst_bout",  32'(bus.bout),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("post_rst_no_valid", 32'(seen), 32'd0);
    end

    for (int v = 0; v < 1000; v++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ 16'(16'hF << (4 * $urandom_range(0, 3)))) : 16'($urandom);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csk_block_subtractor.md
Name: csk_block_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing diff = a - b - bin, one 4-bit block per clock.
- Uses borrow-skip logic: a block whose every bit pair is equal forwards its incoming borrow directly, bypassing the ripple.
- Companion to the combinational carry-skip adder. Lets datapaths share one area-lean subtract unit behind a valid/ready handshake.
- Reports per-operation skip count for observability.

Parameters:
- WIDTH, 16: operand width; multiple of 4, at least 4.
- NBLK, WIDTH/4: derived block count; not user-overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 when a < b + bin (unsigned).
- ovf  output  1  signed overflow.
- skip_cnt  output  $clog2(NBLK)+1  number of blocks whose borrow was skipped.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; out_valid=0; diff=0; bout=0; ovf=0; skip_cnt=0. All internal operand, partial and index registers also clear to 0.
- FSM IDLE -> BUSY:
  - in_ready = (state==IDLE), decoded from the state register (no combinational path from inputs).
  - Accept on in_valid && in_ready: latch a, b, bin; clear block index and skip counter; go to BUSY.
- FSM BUSY, block i at index idx:
  - Compute d_j = a_j ^ b_j ^ br_j.
  - Borrow ripple: br_{j+1} = (~a_j & b_j) | (~(a_j ^ b_j) & br_j).
  - Block propagate P = AND over j of ~(a_j ^ b_j).
  - If P=1: block borrow-out = block borrow-in via the skip mux, and the internal skip counter increments. Otherwise block borrow-out = ripple result.
  - Write the 4 result bits into internal partial register bits [4i+3:4i]; increment idx.
  - After block NBLK-1, go to DONE.
- FSM DONE:
  - On entry, load diff, bout, ovf and skip_cnt from internal registers; out_valid=1.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Hold all outputs stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle and state returns to IDLE.
  - diff/bout/ovf/skip_cnt keep their last values until the next DONE entry.
- Latency: operand accepted at edge k gives out_valid=1 after edge k+NBLK (4 cycles for WIDTH=16). Throughput is at most one operation per NBLK+2 cycles; no overlap.
- in_valid while BUSY/DONE is ignored; operands are not sampled.
- Arithmetic: skip and ripple paths must give identical results. diff/bout must equal the exact unsigned result of a - b - bin over WIDTH+1 bits.
- WIDTH=4: a single BUSY cycle.
- Reset mid-BUSY or mid-DONE: abort immediately to reset values; the partial result is discarded and no out_valid is produced.
- Simultaneous out_ready and in_valid in DONE: the result is retired; new operands are not accepted that cycle (in_ready=0); they are accepted the following IDLE cycle.

Test Plan:
- 0x1234 - 0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, skip_cnt=3, out_valid exactly 4 cycles after accept.
- 0x0000 - 0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, skip_cnt=3.
- 0x8000 - 0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1, skip_cnt=2.
- 0x5555 - 0x5555, bin=1 -> diff=0xFFFF, bout=1, ovf=0, skip_cnt=4 (borrow skipped through all blocks).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs unchanged, in_ready=0. Pulse in_valid during BUSY with other operands -> ignored, result unchanged.
- Deassert rst_n during BUSY cycle 2 -> outputs 0 immediately, in_ready=1 after release, no out_valid. Then a random 1000-vector regression against a - b - bin reference model, with random out_ready.
